spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of the input synchronizers on spi_csb, spi_clock and spi_mosi (minimum 2).
REQ-002 SHALL have parameter TX_WIDTH, default 64, meaning the width of the transmit word shifted out on spi_miso.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port spi_csb, input, 1 bit: SPI chip select, active low, asynchronous to clock.
REQ-006 SHALL have port spi_clock, input, 1 bit: SPI serial clock, mode 0 (idle low), asynchronous to clock.
REQ-007 SHALL have port spi_mosi, input, 1 bit: serial data from the initiator, MSB first.
REQ-008 SHALL have port spi_miso, output, 1 bit: serial data to the initiator, MSB first.
REQ-009 SHALL have port rx_data, output, 8 bits: last fully received MOSI byte.
REQ-010 SHALL have port rx_valid, output, 1 bit: one-cycle strobe marking a new rx_data.
REQ-011 SHALL have port tx_fifo_data, input, TX_WIDTH bits: first-word-fall-through FIFO head, valid while tx_fifo_empty is low.
REQ-012 SHALL have port tx_fifo_rd_en, output, 1 bit: one-cycle pop of the FIFO head.
REQ-013 SHALL have port tx_fifo_empty, input, 1 bit: FIFO empty flag.
REQ-014 SHALL have port frame_active, output, 1 bit: high while in state SHIFT.
REQ-015 SHALL have port frame_abort, output, 1 bit: one-cycle strobe when a frame ends mid-byte.
REQ-016 SHALL have port tx_underrun, output, 1 bit: one-cycle strobe when a word load finds the FIFO empty.

Function
REQ-017 SHALL synchronize spi_csb, spi_clock and spi_mosi through SYNC_STAGES flops each, then register the synchronized spi_clock and spi_csb once more for edge detection; all three inputs SHALL share the same delay.
REQ-018 SHALL implement states WAIT_IDLE, IDLE and SHIFT; reset SHALL enter WAIT_IDLE, and WAIT_IDLE SHALL move to IDLE on the first cycle with synchronized csb high.
REQ-019 In IDLE, a synchronized csb falling edge SHALL load the transmit shift register and enter SHIFT in the same cycle.
REQ-020 Word load rule: if tx_fifo_empty is 0, assert tx_fifo_rd_en for exactly that cycle and capture tx_fifo_data; otherwise load all zeros, pulse tx_underrun and leave tx_fifo_rd_en low.
REQ-021 spi_miso SHALL equal the transmit shift register MSB in SHIFT and SHALL be 0 in every other state.
REQ-022 On each synchronized spi_clock rising edge in SHIFT, SHALL shift the synchronized MOSI bit into the LSB of an 8-bit receive register and increment a 3-bit bit counter.
REQ-023 When the bit counter wraps from 7 to 0, SHALL register the completed byte on rx_data and assert rx_valid in the cycle following the edge-detect cycle; rx_valid SHALL be asserted for exactly one cycle.
REQ-024 On each synchronized spi_clock falling edge in SHIFT, SHALL increment a TX bit counter (width clog2(TX_WIDTH)) and shift the transmit register left by one; when the counter wraps (TX_WIDTH bits sent), SHALL perform a word load per REQ-020 instead of shifting.
REQ-025 A synchronized csb rising edge in SHIFT SHALL return to IDLE, clear both bit counters and discard the partial receive byte; if the RX bit counter was nonzero, SHALL pulse frame_abort once.
REQ-026 If a csb rising edge and a spi_clock edge are detected in the same cycle, the csb edge SHALL take priority and the clock edge SHALL be ignored.
REQ-027 spi_clock edges outside SHIFT SHALL be ignored.
REQ-028 Correct operation SHALL be guaranteed for spi_clock high and low phases of at least SYNC_STAGES+2 clock cycles each.

Reset
REQ-029 While reset is high at a rising clock edge: spi_miso=0, rx_data=0x00, rx_valid=0, tx_fifo_rd_en=0, frame_active=0, frame_abort=0, tx_underrun=0, counters and shift registers cleared, state WAIT_IDLE.
REQ-030 A reset asserted mid-frame SHALL suppress all further rx_valid and tx_fifo_rd_en until csb has been seen high and then falls again.

Verification
REQ-031 clock 100 MHz, spi_clock 5 MHz; one frame sending 0xA5 then 0x3C -> exactly two rx_valid pulses with rx_data 0xA5 then 0x3C; frame_abort never asserted.
REQ-032 FIFO head 0x0123456789ABCDEF, 64-bit frame -> spi_miso bits at the 64 rising spi_clock edges equal the word MSB first; exactly one tx_fifo_rd_en pulse, in the csb-fall cycle.
REQ-033 FIFO empty at csb fall, 64-bit frame -> spi_miso constant 0, one tx_underrun pulse, no tx_fifo_rd_en.
REQ-034 128-bit frame with two words queued -> two tx_fifo_rd_en pulses, the second on the falling spi_clock edge after bit 64; spi_miso shows word 1 followed by word 2.
REQ-035 csb raised after 5 bits -> no rx_valid, one frame_abort pulse; next frame sending 0xFF -> one rx_valid with rx_data 0xFF.
REQ-036 reset held 1 cycle after 3 bits with csb still low -> all outputs zero, no rx_valid or tx_fifo_rd_en for the remaining bits; after csb high then low, a frame sending 0x5A -> rx_data 0x5A.

Source files
------------

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_responder
// Brief    : Mode-0 SPI responder that oversamples the SPI pins on the system clock
//            and shifts FIFO words out on MISO while collecting bytes from MOSI.
// Revision : 1.0
// ============================================================================
module spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int TX_WIDTH    = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                spi_csb,
    input  logic                spi_clock,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_fifo_data,
    output logic                tx_fifo_rd_en,
    input  logic                tx_fifo_empty,
    output logic                frame_active,
    output logic                frame_abort,
    output logic                tx_underrun
);

    localparam int                CNT_W     = (TX_WIDTH > 1) ? $clog2(TX_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  c_TX_LAST = CNT_W'(TX_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_csb_d;
    logic                   r_sclk_d;

    logic [7:0]             r_rx_sr;
    logic [2:0]             r_rx_cnt;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic [TX_WIDTH-1:0]    r_tx_sr;
    logic [CNT_W-1:0]       r_tx_cnt;

    logic w_csb, w_sclk, w_mosi;
    logic w_csb_fall, w_csb_rise, w_sclk_rise, w_sclk_fall;
    logic w_load, w_abort, w_clr, w_rx_step, w_tx_step;

    // Synchronizers reset to 0 so a reset taken with csb low is not mistaken for a new frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_csb_sync  <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_csb_d     <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], spi_csb};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clock};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_csb_d     <= r_csb_sync[SYNC_STAGES-1];
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_csb       = r_csb_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_csb_fall  = ~w_csb & r_csb_d;
    assign w_csb_rise  = w_csb & ~r_csb_d;
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        w_clr       = 1'b0;
        w_rx_step   = 1'b0;
        w_tx_step   = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (w_csb) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_csb_fall) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                // A csb rise masks any clock edge seen in the same cycle.
                if (w_csb_rise) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                    w_abort     = (r_rx_cnt != 3'd0);
                end else begin
                    w_rx_step = w_sclk_rise;
                    if (w_sclk_fall) begin
                        w_tx_step = 1'b1;
                        w_load    = (r_tx_cnt == c_TX_LAST);
                    end
                end
            end
            default: w_state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= WAIT_IDLE;
            r_rx_sr    <= '0;
            r_rx_cnt   <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_sr    <= '0;
            r_tx_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_valid <= 1'b0;
            if (w_clr) begin
                r_rx_sr  <= '0;
                r_rx_cnt <= '0;
                r_tx_cnt <= '0;
            end
            if (w_rx_step) begin
                r_rx_sr  <= {r_rx_sr[6:0], w_mosi};
                r_rx_cnt <= r_rx_cnt + 3'd1;
                if (r_rx_cnt == 3'd7) begin
                    r_rx_data  <= {r_rx_sr[6:0], w_mosi};
                    r_rx_valid <= 1'b1;
                end
            end
            if (w_load) begin
                r_tx_sr <= tx_fifo_empty ? '0 : tx_fifo_data;
            end else if (w_tx_step) begin
                r_tx_sr <= r_tx_sr << 1;
            end
            if (w_tx_step) begin
                r_tx_cnt <= (r_tx_cnt == c_TX_LAST) ? '0 : r_tx_cnt + CNT_W'(1);
            end
        end
    end

    // Load strobes are combinational so the FWFT head is popped in the load cycle itself.
    assign tx_fifo_rd_en = w_load & ~tx_fifo_empty & ~reset;
    assign tx_underrun   = w_load & tx_fifo_empty & ~reset;
    assign frame_abort   = w_abort & ~reset;
    assign frame_active  = (r_state == SHIFT);
    assign spi_miso      = (r_state == SHIFT) & r_tx_sr[TX_WIDTH-1] & ~reset;
    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_responder
// Brief    : Directed self-checking bench for spi_responder (100 MHz clock, 5 MHz SPI).
// Revision : 1.0
// ============================================================================
module tb_spi_responder;

    localparam int TXW = 64;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           spi_csb = 1'b1;
    logic           spi_clock = 1'b0;
    logic           spi_mosi = 1'b0;
    logic           spi_miso;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [TXW-1:0] tx_fifo_data;
    logic           tx_fifo_rd_en;
    logic           tx_fifo_empty;
    logic           frame_active;
    logic           frame_abort;
    logic           tx_underrun;

    always #5 clock = ~clock;

    spi_responder #(.SYNC_STAGES(2), .TX_WIDTH(TXW)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .spi_csb       (spi_csb),
        .spi_clock     (spi_clock),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_fifo_data  (tx_fifo_data),
        .tx_fifo_rd_en (tx_fifo_rd_en),
        .tx_fifo_empty (tx_fifo_empty),
        .frame_active  (frame_active),
        .frame_abort   (frame_abort),
        .tx_underrun   (tx_underrun)
    );

    // Two-entry FWFT FIFO model
    logic [TXW-1:0] fifo_mem [0:1];
    int             fifo_cnt = 0;
    logic [1:0]     head = 2'd0;
    logic           fifo_clr = 1'b1;

    assign tx_fifo_empty = (int'(head) >= fifo_cnt);
    assign tx_fifo_data  = fifo_mem[head[0]];

    always @(posedge clock) begin
        if (fifo_clr)                            head <= 2'd0;
        else if (tx_fifo_rd_en && head != 2'd3)  head <= head + 2'd1;
    end

    // Event monitor
    int         n_rx, n_pop, n_under, n_abort, rise_cnt;
    logic [7:0] rx_log  [0:3];
    int         pop_bit [0:3];
    logic       clr = 1'b1;

    always @(negedge clock) begin
        if (clr) begin
            n_rx = 0; n_pop = 0; n_under = 0; n_abort = 0;
        end else begin
            if (rx_valid) begin
                if (n_rx < 4) rx_log[n_rx] = rx_data;
                n_rx++;
            end
            if (tx_fifo_rd_en) begin
                if (n_pop < 4) pop_bit[n_pop] = rise_cnt;
                n_pop++;
            end
            if (tx_underrun) n_under++;
            if (frame_abort) n_abort++;
        end
    end

    int             n_vec = 0;
    int             n_err = 0;
    logic [127:0]   miso_cap;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic half_period();
        repeat (10) @(negedge clock);
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        repeat (2) @(negedge clock);
        clr = 1'b0;
    endtask

    task automatic set_fifo(input int cnt, input logic [TXW-1:0] w0, input logic [TXW-1:0] w1);
        fifo_mem[0] = w0;
        fifo_mem[1] = w1;
        fifo_cnt    = cnt;
        fifo_clr    = 1'b1;
        repeat (2) @(negedge clock);
        fifo_clr    = 1'b0;
        clear_stats();
    endtask

    // MISO is sampled just before each rising edge. csb rises while spi_clock is still
    // high after the last bit, so the trailing falling edge lands outside the frame.
    task automatic spi_frame(input int nbits, input logic [127:0] mosi_word, input int reset_at);
        rise_cnt = 0;
        miso_cap = '0;
        @(negedge clock);
        spi_csb = 1'b0;
        half_period();
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mosi_word[nbits-1-i];
            half_period();
            miso_cap[nbits-1-i] = spi_miso;
            spi_clock = 1'b1;
            rise_cnt++;
            half_period();
            if (i != nbits - 1) spi_clock = 1'b0;
            if (i + 1 == reset_at) begin
                reset = 1'b1;
                @(negedge clock);
                check("rst_miso",   spi_miso,     0);
                check("rst_active", frame_active, 0);
                check("rst_rxdata", rx_data,      0);
                check("rst_rden",   tx_fifo_rd_en, 0);
                reset = 1'b0;
                clear_stats();
            end
        end
        check("frame_active", frame_active, (reset_at == 0) ? 1 : 0);
        spi_csb = 1'b1;
        half_period();
        spi_clock = 1'b0;
        half_period();
        half_period();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_miso",   spi_miso,      0);
        check("reset_rxdata", rx_data,       0);
        check("reset_rxval",  rx_valid,      0);
        check("reset_rden",   tx_fifo_rd_en, 0);
        check("reset_active", frame_active,  0);
        check("reset_abort",  frame_abort,   0);
        check("reset_under",  tx_underrun,   0);
        reset    = 1'b0;
        fifo_clr = 1'b0;
        clr      = 1'b0;
        repeat (10) @(negedge clock);

        // Two-byte receive
        set_fifo(1, 64'h1111_2222_3333_4444, 64'h0);
        spi_frame(16, 128'hA53C, 0);
        check("rx2_count", n_rx, 2);
        check("rx2_byte0", rx_log[0], 8'hA5);
        check("rx2_byte1", rx_log[1], 8'h3C);
        check("rx2_abort", n_abort, 0);

        // Single 64-bit word out
        set_fifo(1, 64'h0123_4567_89AB_CDEF, 64'h0);
        spi_frame(64, 128'h0, 0);
        check("tx64_miso",   miso_cap, 128'h0123_4567_89AB_CDEF);
        check("tx64_pops",   n_pop, 1);
        check("tx64_popbit", pop_bit[0], 0);
        check("tx64_under",  n_under, 0);

        // Empty FIFO at frame start
        set_fifo(0, 64'h0, 64'h0);
        spi_frame(64, 128'h0, 0);
        check("und_miso",  miso_cap, 128'h0);
        check("und_count", n_under, 1);
        check("und_pops",  n_pop, 0);

        // Two words back to back
        set_fifo(2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        spi_frame(128, 128'h0, 0);
        check("tx128_miso",    miso_cap, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("tx128_pops",    n_pop, 2);
        check("tx128_popbit1", pop_bit[1], 64);

        // Aborted partial byte, then a clean byte
        set_fifo(0, 64'h0, 64'h0);
        spi_frame(5, 128'h1F, 0);
        check("abort_rx",    n_rx, 0);
        check("abort_count", n_abort, 1);
        clear_stats();
        spi_frame(8, 128'hFF, 0);
        check("ff_count", n_rx, 1);
        check("ff_byte",  rx_log[0], 8'hFF);
        check("ff_abort", n_abort, 0);

        // Reset mid-frame, then recovery
        set_fifo(1, 64'hAAAA_5555_AAAA_5555, 64'h0);
        spi_frame(8, 128'hC3, 3);
        check("midrst_rx",    n_rx, 0);
        check("midrst_pops",  n_pop, 0);
        check("midrst_abort", n_abort, 0);
        clear_stats();
        spi_frame(8, 128'h5A, 0);
        check("recov_count", n_rx, 1);
        check("recov_byte",  rx_log[0], 8'h5A);
        check("recov_rxdata", rx_data, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
